// File: rtl/q_update_ctrl_if.sv
// Request/response and Q-table RAM signals of the Q-learning update controller.
// slave is the controller's view; master is the agent plus RAM side.
interface q_update_ctrl_if;
  logic        start;
  logic [5:0]  state;
  logic [2:0]  action;
  logic [3:0]  reward;
  logic [5:0]  next_state;
  logic        next_term;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  best_action;
  logic [31:0] max_q;
  logic [31:0] new_q;
  logic        q_rd_en;
  logic [7:0]  q_rd_addr;
  logic [31:0] q_rd_data;
  logic        q_wr_en;
  logic [7:0]  q_wr_addr;
  logic [31:0] q_wr_data;

  modport slave (
    input  start, state, action, reward, next_state, next_term, q_rd_data,
    output busy, done, err, best_action, max_q, new_q,
           q_rd_en, q_rd_addr, q_wr_en, q_wr_addr, q_wr_data
  );

  modport master (
    output start, state, action, reward, next_state, next_term, q_rd_data,
    input  busy, done, err, best_action, max_q, new_q,
           q_rd_en, q_rd_addr, q_wr_en, q_wr_addr, q_wr_data
  );
endinterface

// File: rtl/q_update_ctrl.sv
// Sequences one Q-learning update on the shared Q7.24 Q-table RAM:
// max over Q(s',*), read old Q(s,a), Q' = old + LR*(r + GAMMA*maxQ - old), write back.
module q_update_ctrl #(
  parameter int                 N_STATES   = 36,
  parameter int                 N_ACTIONS  = 4,
  parameter int                 FRAC       = 24,
  parameter logic signed [31:0] DISCOUNT   = 32'sh00E66666,
  parameter logic signed [31:0] LEARN_RATE = 32'sh00333333
) (
  input  logic         clk,
  input  logic         reset_n,
  q_update_ctrl_if.slave bus
);

  localparam int         DATA_W = 32;
  localparam logic [5:0] N_ST   = 6'(N_STATES);
  localparam logic [2:0] N_ACT  = 3'(N_ACTIONS);

  typedef enum logic [2:0] {
    IDLE, RD_MAX, RD_OLD, WAIT_RD, CALC1, CALC2, WRITE, DONE
  } fsm_t;

  function automatic logic signed [63:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(64-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Q7.24 multiply: full 64-bit product, arithmetic shift truncates toward -inf.
  function automatic logic signed [63:0] mul_shift(input logic signed [63:0] a,
                                                   input logic signed [DATA_W-1:0] coef);
    logic signed [63:0] prod;
    prod = a * sext(coef);
    return prod >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh000000007FFFFFFF) return 32'sh7FFFFFFF;
    if (v < 64'shFFFFFFFF80000000) return 32'sh80000000;
    return v[DATA_W-1:0];
  endfunction

  fsm_t fsm_q, fsm_d;
  logic [1:0] rd_cnt;
  logic       err_q;
  logic       rd_vld_p0, rd_max_p0;
  logic [1:0] rd_idx_p0;
  logic [1:0] best_q;
  logic signed [DATA_W-1:0] max_q_r, new_q_r;

  logic [5:0] req_state, req_next;
  logic [1:0] req_action;
  logic [3:0] req_reward;
  logic signed [DATA_W-1:0] run_max;
  logic [1:0]               run_best;
  logic signed [DATA_W-1:0] old_p0;
  logic signed [63:0]       diff_p1;
  logic signed [DATA_W-1:0] upd_p2;

  logic accept, invalid, idle_like;
  logic signed [63:0] rew_ext, target;

  assign idle_like = (fsm_q == IDLE) || (fsm_q == DONE);
  assign accept    = bus.start && idle_like;
  assign invalid   = (bus.state >= N_ST) || (bus.action >= N_ACT) ||
                     (!bus.next_term && (bus.next_state >= N_ST));

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE, DONE: begin
        if (!accept)      fsm_d = IDLE;
        else if (invalid) fsm_d = DONE;
        else              fsm_d = bus.next_term ? RD_OLD : RD_MAX;
      end
      RD_MAX:  if (rd_cnt == 2'd3) fsm_d = RD_OLD;
      RD_OLD:  fsm_d = WAIT_RD;
      WAIT_RD: fsm_d = CALC1;
      CALC1:   fsm_d = CALC2;
      CALC2:   fsm_d = WRITE;
      WRITE:   fsm_d = DONE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= IDLE;
      rd_cnt    <= 2'd0;
      err_q     <= 1'b0;
      rd_vld_p0 <= 1'b0;
      rd_max_p0 <= 1'b0;
      rd_idx_p0 <= 2'd0;
      best_q    <= 2'd0;
      max_q_r   <= '0;
      new_q_r   <= '0;
    end else begin
      fsm_q     <= fsm_d;
      rd_vld_p0 <= bus.q_rd_en;
      rd_max_p0 <= (fsm_q == RD_MAX);
      rd_idx_p0 <= rd_cnt;
      if (accept) begin
        err_q  <= invalid;
        rd_cnt <= 2'd0;
      end else if (fsm_q == RD_MAX) begin
        rd_cnt <= rd_cnt + 2'd1;
      end
      // Visible results change only as the update completes; rejected requests leave them alone.
      if (fsm_q == WRITE) begin
        max_q_r <= run_max;
        best_q  <= run_best;
        new_q_r <= upd_p2;
      end
    end
  end

  assign rew_ext = {60'd0, req_reward};
  assign target  = (rew_ext <<< FRAC) + mul_shift(sext(run_max), DISCOUNT);

  always_ff @(posedge clk) begin
    if (accept) begin
      req_state  <= bus.state;
      req_action <= bus.action[1:0];
      req_reward <= bus.reward;
      req_next   <= bus.next_state;
      run_max    <= '0;
      run_best   <= 2'd0;
    end
    // Stage p0: read data returns one cycle after the strobe
    if (rd_vld_p0) begin
      if (rd_max_p0) begin
        if ((rd_idx_p0 == 2'd0) || ($signed(bus.q_rd_data) > run_max)) begin
          run_max  <= bus.q_rd_data;
          run_best <= rd_idx_p0;
        end
      end else begin
        old_p0 <= bus.q_rd_data;
      end
    end
    // Stage p1: temporal-difference error
    if (fsm_q == CALC1) diff_p1 <= target - sext(old_p0);
    // Stage p2: scaled update with saturation
    if (fsm_q == CALC2) upd_p2 <= sat32(sext(old_p0) + mul_shift(diff_p1, LEARN_RATE));
  end

  assign bus.busy        = !idle_like;
  assign bus.done        = (fsm_q == DONE);
  assign bus.err         = (fsm_q == DONE) && err_q;
  assign bus.best_action = best_q;
  assign bus.max_q       = max_q_r;
  assign bus.new_q       = new_q_r;
  assign bus.q_rd_en     = (fsm_q == RD_MAX) || (fsm_q == RD_OLD);
  assign bus.q_rd_addr   = (fsm_q == RD_MAX) ? {req_next, rd_cnt} :
                           (fsm_q == RD_OLD) ? {req_state, req_action} : 8'd0;
  assign bus.q_wr_en     = (fsm_q == WRITE);
  assign bus.q_wr_addr   = (fsm_q == WRITE) ? {req_state, req_action} : 8'd0;
  assign bus.q_wr_data   = (fsm_q == WRITE) ? upd_p2 : '0;

endmodule
